instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/instruction_fetch_pkg.sv | 22 ++
 rtl/instruction_fetch_add32.sv | 10 +
 rtl/instruction_fetch.sv | 170 +++++++++++++++++
 tb/tb_instruction_fetch.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: next-PC select codes,
// fetch FSM states and the default bubble instruction.
package instruction_fetch_pkg;

  localparam logic [1:0] PC_SEQ = 2'b00;
  localparam logic [1:0] PC_BR  = 2'b01;
  localparam logic [1:0] PC_REG = 2'b10;
  localparam logic [1:0] PC_JMP = 2'b11;

  localparam logic [31:0] IF_NOP_INST = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_HOLD  = 2'd1,
    ST_KILL  = 2'd2
  } if_state_e;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/instruction_fetch_add32.sv
// 32-bit adder used as the PC incrementer; the sum wraps modulo 2^32.
module add32 (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [31:0] o_sum
);

  assign o_sum = i_a + i_b;

endmodule

// File: rtl/instruction_fetch.sv
// IF stage: issues word fetches to instruction memory, buffers a word that
// arrives under a load-use stall, and drops wrong-path data after a redirect.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = IF_NOP_INST
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        stall_en,
  input  logic [1:0]  pcsource,
  input  logic [31:0] bpc,
  input  logic [31:0] jpc,
  input  logic [31:0] ra,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc4,
  output logic        id_valid
);

  localparam logic [31:0] RESET_PC_W = word_align(RESET_PC);

  if_state_e   r_state,     w_state_nxt;
  logic [31:0] r_pc,        w_pc_nxt;
  logic [31:0] r_req_addr,  w_req_addr_nxt;
  logic        r_req,       w_req_nxt;
  logic [31:0] r_id_inst,   w_id_inst_nxt;
  logic [31:0] r_id_pc4,    w_id_pc4_nxt;
  logic        r_id_valid,  w_id_valid_nxt;
  logic [31:0] r_hold_inst, w_hold_inst_nxt;

  logic [31:0] w_pc4;
  logic [31:0] w_target;
  logic        w_ack;
  logic        w_redirect;

  add32 u_pc_inc (
    .i_a   (r_pc),
    .i_b   (32'd4),
    .o_sum (w_pc4)
  );

  // An ack only counts against a request we actually have outstanding.
  assign w_ack      = imem_ack & r_req;
  assign w_redirect = r_id_valid & ~stall_en & (pcsource != PC_SEQ);

  always_comb begin
    w_target = w_pc4;
    unique case (pcsource)
      PC_SEQ: w_target = w_pc4;
      PC_BR:  w_target = word_align(bpc);
      PC_REG: w_target = word_align(ra);
      PC_JMP: w_target = word_align(jpc);
      default: w_target = w_pc4;
    endcase
  end

  always_ff @(posedge clk or posedge clrn) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values computed by the combinational block.
    if (clrn) begin
      r_state     <= ST_FETCH;
      r_pc        <= RESET_PC_W;
      r_req_addr  <= RESET_PC_W;
      r_req       <= 1'b0;
      r_id_inst   <= NOP_INST;
      r_id_pc4    <= 32'd0;
      r_id_valid  <= 1'b0;
      r_hold_inst <= 32'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_pc        <= w_pc_nxt;
      r_req_addr  <= w_req_addr_nxt;
      r_req       <= w_req_nxt;
      r_id_inst   <= w_id_inst_nxt;
      r_id_pc4    <= w_id_pc4_nxt;
      r_id_valid  <= w_id_valid_nxt;
      r_hold_inst <= w_hold_inst_nxt;
    end
  end

  always_comb begin
    // NOTE: every output of this block takes a default before any branch, so
    // no path leaves a value unassigned and no latch is inferred.
    w_state_nxt     = r_state;
    w_pc_nxt        = r_pc;
    w_req_addr_nxt  = r_req_addr;
    w_req_nxt       = r_req;
    w_id_inst_nxt   = r_id_inst;
    w_id_pc4_nxt    = r_id_pc4;
    w_id_valid_nxt  = r_id_valid;
    w_hold_inst_nxt = r_hold_inst;

    // ID consumes a slot whenever it is not stalled; a bubble unless a word lands.
    if (!stall_en) begin
      w_id_inst_nxt  = NOP_INST;
      w_id_valid_nxt = 1'b0;
    end
    if (w_redirect) begin
      w_pc_nxt = w_target;
    end

    unique case (r_state)
      ST_FETCH: begin
        if (w_ack) begin
          if (w_redirect) begin
            w_req_addr_nxt = w_target;
          end else if (stall_en) begin
            w_hold_inst_nxt = imem_rdata;
            w_req_nxt       = 1'b0;
            w_state_nxt     = ST_HOLD;
          end else begin
            w_id_inst_nxt  = imem_rdata;
            w_id_pc4_nxt   = w_pc4;
            w_id_valid_nxt = 1'b1;
            w_pc_nxt       = w_pc4;
            w_req_addr_nxt = w_pc4;
          end
        end else if (!r_req) begin
          w_req_nxt      = 1'b1;
          w_req_addr_nxt = w_pc_nxt;
        end else if (w_redirect) begin
          // The outstanding request is wrong-path but must still complete.
          w_state_nxt = ST_KILL;
        end
      end

      ST_HOLD: begin
        if (w_redirect) begin
          w_hold_inst_nxt = 32'd0;
          w_req_nxt       = 1'b1;
          w_req_addr_nxt  = w_target;
          w_state_nxt     = ST_FETCH;
        end else if (!stall_en) begin
          w_id_inst_nxt   = r_hold_inst;
          w_id_pc4_nxt    = w_pc4;
          w_id_valid_nxt  = 1'b1;
          w_pc_nxt        = w_pc4;
          w_req_nxt       = 1'b1;
          w_req_addr_nxt  = w_pc4;
          w_state_nxt     = ST_FETCH;
        end
      end

      ST_KILL: begin
        if (w_ack) begin
          w_req_addr_nxt = w_pc_nxt;
          w_state_nxt    = ST_FETCH;
        end
      end

      default: begin
        w_state_nxt = ST_FETCH;
      end
    endcase
  end

  assign imem_req  = r_req;
  assign imem_addr = r_req_addr;
  assign pc        = r_pc;
  assign id_inst   = r_id_inst;
  assign id_pc4    = r_id_pc4;
  assign id_valid  = r_id_valid;

endmodule

// File: tb/tb_instruction_fetch.sv
// Scenario bench for instruction_fetch: a memory model answers requests with
// rdata = address and a scoreboard tracks the words that must reach ID in order.
module tb_instruction_fetch;

  localparam logic [31:0] TB_NOP = 32'h0000_0013;

  logic        clk;
  logic        clrn;
  logic        stall_en;
  logic [1:0]  pcsource;
  logic [31:0] bpc, jpc, ra;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] pc;
  logic [31:0] id_inst;
  logic [31:0] id_pc4;
  logic        id_valid;

  int checks   = 0;
  int failures = 0;

  logic [63:0] sb_q[$];
  logic [31:0] exp_addr;
  logic        mon_stall;
  logic        mon_rst;
  logic [63:0] mon_exp;

  instruction_fetch #(
    .RESET_PC (32'h0000_0000),
    .NOP_INST (TB_NOP)
  ) dut (
    .clk        (clk),
    .clrn       (clrn),
    .stall_en   (stall_en),
    .pcsource   (pcsource),
    .bpc        (bpc),
    .jpc        (jpc),
    .ra         (ra),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .pc         (pc),
    .id_inst    (id_inst),
    .id_pc4     (id_pc4),
    .id_valid   (id_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard consumer: every unstalled edge out of reset loads either the
  // next expected word or a bubble into IF/ID.
  always @(posedge clk) begin
    mon_stall = stall_en;
    mon_rst   = clrn;
    #1;
    if (!mon_rst && !clrn && !mon_stall) begin
      checks++;
      if (id_valid) begin
        if (sb_q.size() == 0) begin
          failures++;
          $display("FAIL sb_extra: got id_inst=%h id_pc4=%h, no word expected", id_inst, id_pc4);
        end else begin
          mon_exp = sb_q.pop_front();
          if ({id_inst, id_pc4} !== mon_exp) begin
            failures++;
            $display("FAIL sb_word: got inst=%h pc4=%h, want inst=%h pc4=%h",
                     id_inst, id_pc4, mon_exp[63:32], mon_exp[31:0]);
          end
        end
      end else if (id_inst !== TB_NOP) begin
        failures++;
        $display("FAIL bubble_inst: got %h, want %h", id_inst, TB_NOP);
      end
    end
  end

  // One clock of stimulus; memory answers with its own address as data.
  task automatic cyc(input bit ack, input bit stall, input logic [1:0] psrc, input bit deliver);
    imem_ack   = ack;
    imem_rdata = ack ? imem_addr : 32'hDEAD_BEEF;
    stall_en   = stall;
    pcsource   = psrc;
    if (ack && deliver) sb_q.push_back({exp_addr, exp_addr + 32'd4});
    @(posedge clk);
    #2;
    imem_ack = 1'b0;
  endtask

  task automatic test_reset();
    clrn = 1'b1; stall_en = 1'b0; pcsource = 2'b00; imem_ack = 1'b0;
    imem_rdata = 32'd0; bpc = 32'd0; jpc = 32'd0; ra = 32'd0;
    repeat (2) @(posedge clk);
    #2;
    checks++;
    if ({pc, imem_req, imem_addr, id_inst, id_pc4, id_valid} !==
        {32'd0, 1'b0, 32'd0, TB_NOP, 32'd0, 1'b0}) begin
      failures++;
      $display("FAIL reset_state: pc=%h req=%b addr=%h inst=%h pc4=%h valid=%b",
               pc, imem_req, imem_addr, id_inst, id_pc4, id_valid);
    end
    clrn = 1'b0;
    cyc(1'b0, 1'b0, 2'b00, 1'b0);
    checks++;
    if ({imem_req, imem_addr, id_valid} !== {1'b1, 32'd0, 1'b0}) begin
      failures++;
      $display("FAIL first_req: req=%b addr=%h valid=%b, want 1/0/0", imem_req, imem_addr, id_valid);
    end
    exp_addr = 32'd0;
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({imem_req, imem_addr} !== {1'b1, exp_addr}) begin
        failures++;
        $display("FAIL seq_addr: req=%b addr=%h, want 1/%h", imem_req, imem_addr, exp_addr);
      end
      cyc(1'b1, 1'b0, 2'b00, 1'b1);
      exp_addr = exp_addr + 32'd4;
    end
    checks++;
    if ({pc, imem_addr, sb_q.size() == 0} !== {32'h10, 32'h10, 1'b1}) begin
      failures++;
      $display("FAIL seq_end: pc=%h addr=%h pending=%0d, want 10/10/0", pc, imem_addr, sb_q.size());
    end
  endtask

  task automatic test_stall();
    cyc(1'b1, 1'b1, 2'b00, 1'b1);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({imem_req, id_inst, id_valid, pc} !== {1'b0, 32'hC, 1'b1, 32'h10}) begin
        failures++;
        $display("FAIL stall_frozen: req=%b inst=%h valid=%b pc=%h, want 0/c/1/10",
                 imem_req, id_inst, id_valid, pc);
      end
      if (i < 2) cyc(1'b0, 1'b1, 2'b00, 1'b0);
    end
    cyc(1'b0, 1'b0, 2'b00, 1'b0);
    exp_addr = 32'h14;
    checks++;
    if ({id_inst, id_valid, imem_req, imem_addr} !== {32'h10, 1'b1, 1'b1, 32'h14}) begin
      failures++;
      $display("FAIL stall_release: inst=%h valid=%b req=%b addr=%h, want 10/1/1/14",
               id_inst, id_valid, imem_req, imem_addr);
    end
    cyc(1'b1, 1'b0, 2'b00, 1'b1);
    exp_addr = 32'h18;
  endtask

  task automatic test_wait_states();
    cyc(1'b0, 1'b0, 2'b00, 1'b0);
    checks++;
    if ({id_valid, imem_req, imem_addr} !== {1'b0, 1'b1, 32'h18}) begin
      failures++;
      $display("FAIL wait_bubble: valid=%b req=%b addr=%h, want 0/1/18", id_valid, imem_req, imem_addr);
    end
    cyc(1'b1, 1'b0, 2'b00, 1'b1);
    exp_addr = 32'h1C;
    cyc(1'b0, 1'b1, 2'b00, 1'b0);
    checks++;
    if ({id_inst, id_valid, imem_addr} !== {32'h18, 1'b1, 32'h1C}) begin
      failures++;
      $display("FAIL wait_stall_hold: inst=%h valid=%b addr=%h, want 18/1/1c", id_inst, id_valid, imem_addr);
    end
    cyc(1'b1, 1'b0, 2'b00, 1'b1);
    exp_addr = 32'h20;
  endtask

  task automatic test_branch();
    bpc = 32'h100;
    cyc(1'b1, 1'b0, 2'b01, 1'b0);
    checks++;
    if ({id_valid, imem_req, imem_addr, pc} !== {1'b0, 1'b1, 32'h100, 32'h100}) begin
      failures++;
      $display("FAIL branch_redirect: valid=%b req=%b addr=%h pc=%h, want 0/1/100/100",
               id_valid, imem_req, imem_addr, pc);
    end
    exp_addr = 32'h100;
    cyc(1'b1, 1'b0, 2'b00, 1'b1);
    ra = 32'h300;
    cyc(1'b1, 1'b0, 2'b10, 1'b0);
    checks++;
    if ({id_valid, imem_addr} !== {1'b0, 32'h300}) begin
      failures++;
      $display("FAIL reg_redirect: valid=%b addr=%h, want 0/300", id_valid, imem_addr);
    end
    exp_addr = 32'h300;
    cyc(1'b1, 1'b0, 2'b00, 1'b1);
    // Word 0x304 is buffered under stall, then the redirect must drop it.
    cyc(1'b1, 1'b1, 2'b00, 1'b0);
    cyc(1'b0, 1'b1, 2'b00, 1'b0);
    bpc = 32'h400;
    cyc(1'b0, 1'b0, 2'b01, 1'b0);
    checks++;
    if ({id_valid, imem_req, imem_addr, pc} !== {1'b0, 1'b1, 32'h400, 32'h400}) begin
      failures++;
      $display("FAIL hold_redirect: valid=%b req=%b addr=%h pc=%h, want 0/1/400/400",
               id_valid, imem_req, imem_addr, pc);
    end
    exp_addr = 32'h400;
    cyc(1'b1, 1'b0, 2'b00, 1'b1);
    exp_addr = 32'h404;
  endtask

  task automatic test_jump_kill();
    jpc = 32'h200;
    cyc(1'b0, 1'b0, 2'b11, 1'b0);
    checks++;
    if ({imem_req, imem_addr, pc, id_valid} !== {1'b1, 32'h404, 32'h200, 1'b0}) begin
      failures++;
      $display("FAIL kill_enter: req=%b addr=%h pc=%h valid=%b, want 1/404/200/0",
               imem_req, imem_addr, pc, id_valid);
    end
    for (int i = 0; i < 2; i++) begin
      cyc(1'b0, 1'b0, 2'b00, 1'b0);
      checks++;
      if ({imem_req, imem_addr} !== {1'b1, 32'h404}) begin
        failures++;
        $display("FAIL kill_addr_stable: req=%b addr=%h, want 1/404", imem_req, imem_addr);
      end
    end
    cyc(1'b1, 1'b0, 2'b00, 1'b0);
    checks++;
    if ({imem_req, imem_addr, id_valid} !== {1'b1, 32'h200, 1'b0}) begin
      failures++;
      $display("FAIL kill_exit: req=%b addr=%h valid=%b, want 1/200/0", imem_req, imem_addr, id_valid);
    end
    exp_addr = 32'h200;
    cyc(1'b1, 1'b0, 2'b00, 1'b1);
    exp_addr = 32'h204;
  endtask

  task automatic test_wrap();
    jpc = 32'hFFFF_FFFF;
    cyc(1'b1, 1'b0, 2'b11, 1'b0);
    checks++;
    if ({imem_addr, pc} !== {32'hFFFF_FFFC, 32'hFFFF_FFFC}) begin
      failures++;
      $display("FAIL wrap_target: addr=%h pc=%h, want fffffffc/fffffffc", imem_addr, pc);
    end
    exp_addr = 32'hFFFF_FFFC;
    cyc(1'b1, 1'b0, 2'b00, 1'b1);
    checks++;
    if ({id_pc4, imem_addr, pc} !== {32'd0, 32'd0, 32'd0}) begin
      failures++;
      $display("FAIL wrap_pc4: pc4=%h addr=%h pc=%h, want 0/0/0", id_pc4, imem_addr, pc);
    end
    exp_addr = 32'd0;
    cyc(1'b1, 1'b0, 2'b00, 1'b1);
    exp_addr = 32'd4;
  endtask

  task automatic test_reset_in_hold();
    cyc(1'b1, 1'b1, 2'b00, 1'b0);
    cyc(1'b0, 1'b1, 2'b00, 1'b0);
    checks++;
    if (imem_req !== 1'b0) begin
      failures++;
      $display("FAIL hold_entry: req=%b, want 0", imem_req);
    end
    #1 clrn = 1'b1;
    #1;
    checks++;
    if ({pc, imem_req, imem_addr, id_inst, id_pc4, id_valid} !==
        {32'd0, 1'b0, 32'd0, TB_NOP, 32'd0, 1'b0}) begin
      failures++;
      $display("FAIL hold_reset_state: pc=%h req=%b addr=%h inst=%h pc4=%h valid=%b",
               pc, imem_req, imem_addr, id_inst, id_pc4, id_valid);
    end
    repeat (2) @(posedge clk);
    #2;
    clrn = 1'b0;
    cyc(1'b0, 1'b0, 2'b00, 1'b0);
    checks++;
    if ({imem_req, imem_addr} !== {1'b1, 32'd0}) begin
      failures++;
      $display("FAIL reset_first_req: req=%b addr=%h, want 1/0", imem_req, imem_addr);
    end
    exp_addr = 32'd0;
    cyc(1'b1, 1'b0, 2'b00, 1'b1);
    #2;
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL sb_drain: %0d words never delivered, want 0", sb_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_wait_states();
    test_branch();
    test_jump_kill();
    test_wrap();
    test_reset_in_hold();
    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, limit 100000 time units");
    $fatal(1);
  end

endmodule
